// File: rtl/eye_opening_monitor.sv
// Purpose : measures vertical eye opening (min_high - max_low) over WINDOW valid slicer samples.
// Latency : opening_ready_o pulses the cycle after the WINDOW-th valid sample is registered.
// Backpr. : none; samples are consumed whenever sample_valid_i is high in ACCUM, otherwise dropped.
//
// Ports:
//   clk_i            sampling-domain clock
//   rst_n_i          synchronous active-low reset
//   enable_i         run measurement; low aborts the current window and idles
//   sample_i         real slicer-input voltage at the sampling instant
//   sample_valid_i   sample_i is valid this cycle
//   opening_o        last measured eye opening, held between reports
//   opening_ready_o  one-cycle pulse when opening_o has just been updated
//   busy_o           high while settling or accumulating
//   sample_count_o   valid samples taken in the current window (saturates at WINDOW)
module eye_opening_monitor #(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned SETTLE = 64,
  parameter real         THRESH = 0.0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  real                          sample_i,
  input  logic                         sample_valid_i,
  output real                          opening_o,
  output logic                         opening_ready_o,
  output logic                         busy_o,
  output logic [$clog2(WINDOW+1)-1:0]  sample_count_o
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  // Sentinels chosen far outside any physical slicer voltage so the first
  // sample on each side always replaces them.
  localparam real MIN_HIGH_INIT = 1.0e30;
  localparam real MAX_LOW_INIT  = -1.0e30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_REPORT
  } state_t;

  state_t        state_q,      state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [CW-1:0] count_q,      count_d;
  real           min_high_q,   min_high_d;
  real           max_low_q,    max_low_d;
  logic          seen_high_q,  seen_high_d;
  logic          seen_low_q,   seen_low_d;
  real           opening_q,    opening_d;
  logic          acc_clr;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    count_d      = count_q;
    min_high_d   = min_high_q;
    max_low_d    = max_low_q;
    seen_high_d  = seen_high_q;
    seen_low_d   = seen_low_q;
    opening_d    = opening_q;
    acc_clr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          if (SETTLE == 0) begin
            state_d = S_ACCUM;
            acc_clr = 1'b1;
          end else begin
            state_d      = S_SETTLE;
            settle_cnt_d = SETTLE_LD;
          end
        end
      end

      S_SETTLE: begin
        // Samples are ignored here; the counter was loaded with SETTLE, so the
        // block spends exactly SETTLE cycles blanked before accumulating.
        settle_cnt_d = settle_cnt_q - SW'(1);
        if (settle_cnt_q <= SW'(1)) begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
        end
      end

      S_ACCUM: begin
        if (sample_valid_i) begin
          count_d = count_q + CW'(1);
          if (sample_i >= THRESH) begin
            if (sample_i < min_high_q) begin
              min_high_d = sample_i;
            end
            seen_high_d = 1'b1;
          end else begin
            if (sample_i > max_low_q) begin
              max_low_d = sample_i;
            end
            seen_low_d = 1'b1;
          end
          // The closing sample is folded in above, so the result uses the
          // post-update extremes and is visible during the REPORT cycle.
          if (count_q == WIN_LAST) begin
            state_d   = S_REPORT;
            opening_d = (seen_high_d && seen_low_d) ? (min_high_d - max_low_d) : 0.0;
          end
        end
      end

      S_REPORT: begin
        if (SETTLE == 0) begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
        end else begin
          state_d      = S_SETTLE;
          settle_cnt_d = SETTLE_LD;
        end
      end

      default: begin
        state_d = S_IDLE;
        acc_clr = 1'b1;
      end
    endcase

    // Disable wins over everything: a window in progress is thrown away and
    // the previously reported opening is kept.
    if (!enable_i) begin
      state_d      = S_IDLE;
      settle_cnt_d = '0;
      opening_d    = opening_q;
      acc_clr      = 1'b1;
    end

    if (acc_clr) begin
      count_d     = '0;
      min_high_d  = MIN_HIGH_INIT;
      max_low_d   = MAX_LOW_INIT;
      seen_high_d = 1'b0;
      seen_low_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      count_q      <= '0;
      min_high_q   <= MIN_HIGH_INIT;
      max_low_q    <= MAX_LOW_INIT;
      seen_high_q  <= 1'b0;
      seen_low_q   <= 1'b0;
      opening_q    <= 0.0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      count_q      <= count_d;
      min_high_q   <= min_high_d;
      max_low_q    <= max_low_d;
      seen_high_q  <= seen_high_d;
      seen_low_q   <= seen_low_d;
      opening_q    <= opening_d;
    end
  end

  assign opening_o       = opening_q;
  assign opening_ready_o = (state_q == S_REPORT);
  assign busy_o          = (state_q == S_SETTLE) || (state_q == S_ACCUM);
  assign sample_count_o  = count_q;

endmodule

// File: tb/tb_eye_opening_monitor.sv
// Purpose : self-checking bench for eye_opening_monitor with WINDOW=8, SETTLE=2, THRESH=0.0.
// Latency : expects the report pulse right after the edge registering the 8th valid sample.
// Backpr. : n/a; stimulus is cycle-driven, every run is a fixed number of cycles.
module tb_eye_opening_monitor;

  localparam int  WINDOW = 8;
  localparam int  SETTLE = 2;
  localparam real THRESH = 0.0;
  localparam int  CW     = $clog2(WINDOW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  real           sample;
  logic          sample_valid;
  real           opening;
  logic          opening_ready;
  logic          busy;
  logic [CW-1:0] sample_count;

  int  checks      = 0;
  int  failures    = 0;
  int  pulses_seen = 0;
  real win_q[$];
  real exp_open    = 0.0;

  always #5 clk = ~clk;

  eye_opening_monitor #(
    .WINDOW(WINDOW),
    .SETTLE(SETTLE),
    .THRESH(THRESH)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .sample_i        (sample),
    .sample_valid_i  (sample_valid),
    .opening_o       (opening),
    .opening_ready_o (opening_ready),
    .busy_o          (busy),
    .sample_count_o  (sample_count)
  );

  // Reference: eye opening of the samples in win_q, from the plain definition
  // (smallest "high" sample minus largest "low" sample, 0 if a side is empty).
  function automatic real ref_opening();
    real hi = 0.0;
    real lo = 0.0;
    bit  sh = 1'b0;
    bit  sl = 1'b0;
    foreach (win_q[i]) begin
      if (win_q[i] >= THRESH) begin
        if (!sh || win_q[i] < hi) hi = win_q[i];
        sh = 1'b1;
      end else begin
        if (!sl || win_q[i] > lo) lo = win_q[i];
        sl = 1'b1;
      end
    end
    return (sh && sl) ? (hi - lo) : 0.0;
  endfunction

  function automatic bit real_ne(input real a, input real b);
    return ((a - b) > 1.0e-9) || ((b - a) > 1.0e-9);
  endfunction

  task automatic make_random_window();
    win_q.delete();
    for (int i = 0; i < WINDOW; i++) begin
      win_q.push_back(real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then look just after it.
  task automatic run_cycle(input logic en, input logic vld, input real s);
    enable       = en;
    sample_valid = vld;
    sample       = s;
    @(posedge clk);
    #1;
    if (opening_ready) pulses_seen++;
  endtask

  // Cycles before a window starts (IDLE->SETTLE or REPORT->SETTLE, then SETTLE
  // blanking). Valid junk samples are presented throughout; none may count.
  task automatic pre_window(input real junk);
    for (int i = 0; i < 1 + SETTLE; i++) begin
      run_cycle(1'b1, 1'b1, (i % 2 == 0) ? junk : -junk);
    end
  endtask

  task automatic feed(input int start, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) run_cycle(1'b1, 1'b0, (i % 2 == 0) ? 9.0 : -9.0);
      run_cycle(1'b1, 1'b1, win_q[start + i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_cycle(1'b0, 1'b0, 0.0);
    run_cycle(1'b0, 1'b0, 0.0);
    checks++; if (opening_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", opening_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sample_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
    checks++; if (real_ne(opening, 0.0)) begin failures++; $display("FAIL reset_opening got=%f exp=0.0", opening); end
    rst_n = 1'b1;
    run_cycle(1'b0, 1'b1, 0.7);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    win_q = '{0.40, -0.35, 0.25, -0.35, 0.40, -0.30, 0.40, -0.35};
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, 4, 1'b0);
    checks++; if (sample_count !== CW'(4)) begin failures++; $display("FAIL basic_mid_count got=%0d exp=4", sample_count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_mid_busy got=%b exp=1", busy); end
    feed(4, 4, 1'b0);
    exp_open = ref_opening();
    checks++; if (opening_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", opening_ready); end
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL basic_opening got=%f exp=%f", opening, exp_open); end
    checks++; if (sample_count !== CW'(WINDOW)) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", sample_count, WINDOW); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_report_busy got=%b exp=0", busy); end
  endtask

  task automatic test_one_sided();
    win_q.delete();
    for (int i = 0; i < WINDOW; i++) win_q.push_back(0.5);
    pulses_seen = 0;
    pre_window(0.01);
    checks++; if (opening_ready !== 1'b0) begin failures++; $display("FAIL onesided_after_report got=%b exp=0", opening_ready); end
    feed(0, WINDOW, 1'b0);
    exp_open = ref_opening();
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL onesided_pulses got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL onesided_opening got=%f exp=%f", opening, exp_open); end
    win_q.delete();
    for (int i = 0; i < WINDOW; i++) win_q.push_back($urandom_range(0, 1) ? 0.5 : -0.5);
    win_q[0] = 0.5;
    win_q[1] = -0.5;
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, WINDOW, 1'b0);
    exp_open = ref_opening();
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL mixed_pulses got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL mixed_opening got=%f exp=%f", opening, exp_open); end
  endtask

  task automatic test_gapped();
    make_random_window();
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, WINDOW - 1, 1'b1);
    run_cycle(1'b1, 1'b0, 9.0);
    checks++; if (pulses_seen !== 0) begin failures++; $display("FAIL gapped_early_pulse got=%0d exp=0", pulses_seen); end
    checks++; if (sample_count !== CW'(WINDOW - 1)) begin failures++; $display("FAIL gapped_count got=%0d exp=%0d", sample_count, WINDOW - 1); end
    run_cycle(1'b1, 1'b1, win_q[WINDOW - 1]);
    exp_open = ref_opening();
    checks++; if (opening_ready !== 1'b1) begin failures++; $display("FAIL gapped_ready got=%b exp=1", opening_ready); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL gapped_opening got=%f exp=%f", opening, exp_open); end
  endtask

  task automatic test_settle();
    win_q.delete();
    for (int i = 0; i < WINDOW; i++) win_q.push_back((i % 2 == 0) ? 0.5 : -0.5);
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, WINDOW, 1'b0);
    exp_open = ref_opening();
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL settle_pulses got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL settle_opening got=%f exp=%f", opening, exp_open); end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 5; w++) begin
      make_random_window();
      pulses_seen = 0;
      pre_window(0.001);
      feed(0, WINDOW, w[0]);
      exp_open = ref_opening();
      checks++; if (opening_ready !== 1'b1 || pulses_seen !== 1) begin failures++; $display("FAIL b2b_pulse win=%0d got=%b/%0d exp=1/1", w, opening_ready, pulses_seen); end
      checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL b2b_opening win=%0d got=%f exp=%f", w, opening, exp_open); end
    end
  endtask

  task automatic test_abort();
    win_q = '{0.05, -0.05, 0.05, -0.05, 0.05};
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, 5, 1'b0);
    checks++; if (sample_count !== CW'(5)) begin failures++; $display("FAIL abort_pre_count got=%0d exp=5", sample_count); end
    run_cycle(1'b0, 1'b1, 0.05);
    checks++; if (sample_count !== '0) begin failures++; $display("FAIL abort_count got=%0d exp=0", sample_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL abort_opening got=%f exp=%f", opening, exp_open); end
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 0.05);
    checks++; if (pulses_seen !== 0) begin failures++; $display("FAIL abort_pulse got=%0d exp=0", pulses_seen); end
    make_random_window();
    pre_window(0.01);
    feed(0, WINDOW - 1, 1'b0);
    checks++; if (pulses_seen !== 0) begin failures++; $display("FAIL abort_fresh_early got=%0d exp=0", pulses_seen); end
    feed(WINDOW - 1, 1, 1'b0);
    exp_open = ref_opening();
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL abort_fresh_pulse got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL abort_fresh_opening got=%f exp=%f", opening, exp_open); end
    // Disable during the report cycle: the pulse already happened, then idle.
    run_cycle(1'b0, 1'b0, 0.0);
    checks++; if (busy !== 1'b0 || opening_ready !== 1'b0) begin failures++; $display("FAIL report_disable got=busy%b/rdy%b exp=0/0", busy, opening_ready); end
    checks++; if (sample_count !== '0) begin failures++; $display("FAIL report_disable_count got=%0d exp=0", sample_count); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL report_disable_opening got=%f exp=%f", opening, exp_open); end
  endtask

  task automatic test_reset_mid();
    make_random_window();
    pulses_seen = 0;
    pre_window(0.01);
    feed(0, 3, 1'b0);
    rst_n = 1'b0;
    run_cycle(1'b1, 1'b1, 0.3);
    exp_open = 0.0;
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL rstmid_opening got=%f exp=%f", opening, exp_open); end
    checks++; if (busy !== 1'b0 || opening_ready !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=busy%b/rdy%b exp=0/0", busy, opening_ready); end
    checks++; if (sample_count !== '0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", sample_count); end
    rst_n = 1'b1;
    make_random_window();
    pre_window(0.01);
    feed(0, WINDOW - 1, 1'b0);
    checks++; if (pulses_seen !== 0) begin failures++; $display("FAIL rstmid_early_pulse got=%0d exp=0", pulses_seen); end
    feed(WINDOW - 1, 1, 1'b0);
    exp_open = ref_opening();
    checks++; if (pulses_seen !== 1) begin failures++; $display("FAIL rstmid_pulse got=%0d exp=1", pulses_seen); end
    checks++; if (real_ne(opening, exp_open)) begin failures++; $display("FAIL rstmid_opening_after got=%f exp=%f", opening, exp_open); end
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample       = 0.0;
    test_reset();
    test_basic();
    test_one_sided();
    test_gapped();
    test_settle();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eye_opening_monitor.md
Name: eye_opening_monitor

Overview:
- Measures the vertical eye opening at the RX slicer over a fixed window of unit intervals.
- Reports one opening value per window to the TX-equalization parameter-update loop via `opening` / `opening_ready`.
- Inserts a settle gap after each report so the loop's frequency/parameter change takes effect before the next measurement.
- Behavioural SV, real-valued samples, lives in the analog_blocks equalization path.

Parameters:
- WINDOW, 1024, number of valid samples per measurement window (≥2).
- SETTLE, 64, clk cycles of blanking after each report before accumulation restarts (≥0).
- THRESH, 0.0, real slicer decision threshold separating "high" from "low" samples.

Ports:
- clk  input  1  sampling-domain clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  run measurement; low aborts and idles.
- sample  input  real  slicer-input voltage at the sampling instant.
- sample_valid  input  1  sample is valid this cycle.
- opening  output  real  last measured eye opening (min_high − max_low).
- opening_ready  output  1  one-cycle pulse, opening updated this cycle.
- busy  output  1  high in SETTLE or ACCUM.
- sample_count  output  $clog2(WINDOW+1)  valid samples taken in current window.

Behaviour:
- Reset is synchronous and active-low, on posedge clk with rst_n=0:
  - state=IDLE, opening=0.0, opening_ready=0, busy=0, sample_count=0.
  - min_high=+1.0e30, max_low=−1.0e30, seen_high=0, seen_low=0, settle_cnt=0.
- States: IDLE, SETTLE, ACCUM, REPORT.
- IDLE: go to SETTLE when enable=1 and load settle_cnt=SETTLE. If SETTLE=0, go directly to ACCUM.
- SETTLE: decrement settle_cnt every cycle. Samples are ignored. At settle_cnt reaching 0, go to ACCUM and clear the accumulators and sample_count.
- ACCUM: on each cycle with sample_valid=1, sample_count increments.
  - If sample ≥ THRESH: min_high=min(min_high,sample), seen_high=1.
  - If sample < THRESH: max_low=max(max_low,sample), seen_low=1.
  - The sample that makes sample_count reach WINDOW is included in the accumulators. The next state is REPORT.
- REPORT (exactly one cycle):
  - opening_ready=1.
  - opening = min_high−max_low if seen_high and seen_low, else 0.0.
  - Next state is SETTLE with settle_cnt=SETTLE, or ACCUM directly if SETTLE=0.
  - Samples arriving in the REPORT cycle are dropped.
- Latency: opening_ready asserts the cycle after the WINDOW-th valid sample is registered.
- opening holds its value between reports. opening_ready is 0 in every non-REPORT cycle.
- By construction opening>0 whenever both sides are seen. A closed eye appears as a small opening, never negative.
- enable=0 in any state: next state is IDLE, accumulators and sample_count clear, opening is retained.
  - A window in progress is discarded with no pulse.
  - enable=0 in the REPORT cycle still completes that pulse, then the block goes to IDLE.
- Reset asserted mid-window: all state returns to reset values next cycle and no pulse is produced.
- sample_count saturates at WINDOW and wraps to 0 only on accumulator clear.
- busy=1 in SETTLE and ACCUM, 0 in IDLE and REPORT.

Test Plan:
- Basic window (WINDOW=8, SETTLE=2, THRESH=0.0): enable, alternate samples +0.40/−0.35, with one +0.25 and one −0.30 included. Required: after 8 valid samples, a single opening_ready pulse with opening=0.25−(−0.30)=0.55.
- One-sided data: 8 samples all +0.5. Required: opening=0.0 with one pulse. The next window of mixed ±0.5 reports 1.0.
- Gapped valid: sample_valid toggles 1/0 across 16 cycles (8 valid). Required: pulse 1 cycle after the 8th valid sample. Invalid-cycle sample values (±9.0) are ignored, and opening is unaffected by them.
- Settle blanking: samples of ±0.01 presented during SETTLE, followed by ±0.5 in ACCUM. Required: opening=1.0, and the SETTLE samples are excluded.
- Abort: enable dropped after 5 valid samples, re-asserted later. Required: no pulse, opening keeps its prior value, sample_count=0, and a fresh full window is needed for the next pulse.
- Sync reset mid-window: rst_n=0 for 1 cycle after 3 samples. Required: next cycle all outputs are at reset values, and no pulse occurs until enable plus a full SETTLE+WINDOW has elapsed.
